// File: rtl/risk_arbiter.sv
// Round-robin arbiter that shares one pre-trade risk engine among N_REQ strategy requesters.
// Each order is issued as a one-cycle pulse, and the engine's verdict comes back tagged with the requester id.
module risk_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int PRICE_W = 32,
  parameter int SIZE_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_side,
  input  logic [N_REQ*PRICE_W-1:0]   req_price,
  input  logic [N_REQ*SIZE_W-1:0]    req_qty,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rc_valid,
  output logic                       rc_side,
  output logic [PRICE_W-1:0]         rc_price,
  output logic [SIZE_W-1:0]          rc_qty,
  input  logic                       rc_accept,
  output logic                       resp_valid,
  output logic                       resp_accept,
  output logic [ID_W-1:0]            resp_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           accept_cnt,
  output logic [CNT_W-1:0]           reject_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, grant_id_reg, resp_id_reg;
  logic                rc_side_reg, resp_valid_reg, resp_accept_reg;
  logic [PRICE_W-1:0]  rc_price_reg;
  logic [SIZE_W-1:0]   rc_qty_reg;
  logic [CNT_W-1:0]    accept_cnt_reg, reject_cnt_reg;

  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     ptr_next;
  logic                win_found;
  logic                grant;
  int                  scan_idx;

  // Scan upward from rr_ptr with wrap; the first pending requester wins.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(scan_idx);
      end
    end
  end

  assign grant    = (state_reg == IDLE) && !halt && win_found;
  assign ptr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant && (win_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      rc_side_reg     <= 1'b0;
      rc_price_reg    <= '0;
      rc_qty_reg      <= '0;
      resp_valid_reg  <= 1'b0;
      resp_accept_reg <= 1'b0;
      resp_id_reg     <= '0;
      accept_cnt_reg  <= '0;
      reject_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= (state_reg == WAIT);
      if (grant) begin
        rr_ptr_reg   <= ptr_next;
        grant_id_reg <= win_id;
        rc_side_reg  <= req_side[win_id];
        rc_price_reg <= req_price[win_id*PRICE_W +: PRICE_W];
        rc_qty_reg   <= req_qty[win_id*SIZE_W +: SIZE_W];
      end
      // rc_accept only matters in WAIT; pulses at any other time are dropped.
      if (state_reg == WAIT) begin
        resp_accept_reg <= rc_accept;
        resp_id_reg     <= grant_id_reg;
        if (rc_accept) begin
          if (accept_cnt_reg != '1) accept_cnt_reg <= accept_cnt_reg + 1'b1;
        end else begin
          if (reject_cnt_reg != '1) reject_cnt_reg <= reject_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rc_valid    = (state_reg == ISSUE);
  assign busy        = (state_reg != IDLE);
  assign rc_side     = rc_side_reg;
  assign rc_price    = rc_price_reg;
  assign rc_qty      = rc_qty_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_accept = resp_accept_reg;
  assign resp_id     = resp_id_reg;
  assign accept_cnt  = accept_cnt_reg;
  assign reject_cnt  = reject_cnt_reg;

endmodule
